// File: rtl/lcd_bus_controller.sv
// HD44780-style LCD bus controller.
// Each request polls the busy flag, then performs one byte write or read
// (one bus cycle in 8-bit mode, two nibble cycles in 4-bit mode), and
// completes with a 4-phase req/ack handshake.
module lcd_bus_controller #(
  parameter int unsigned BUS_WIDTH    = 8,
  parameter int unsigned HOLD         = 150,
  parameter int unsigned BUSY_TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 rs_pin,
  output logic                 rw_pin,
  output logic                 e_pin,
  inout  wire  [BUS_WIDTH-1:0] data_pins,
  input  logic                 req,
  input  logic [1:0]           op,
  input  logic [7:0]           wr_data,
  output logic [7:0]           rd_data,
  output logic                 ack,
  output logic                 timeout
);

  // Illegal parameter values stop elaboration.
  if (!(BUS_WIDTH == 8 || BUS_WIDTH == 4)) begin : g_bad_width
    $error("lcd_bus_controller: BUS_WIDTH must be 8 or 4");
  end
  if (HOLD < 2 || HOLD > 255) begin : g_bad_hold
    $error("lcd_bus_controller: HOLD must be in 2..255");
  end
  if (BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 65535) begin : g_bad_timeout
    $error("lcd_bus_controller: BUSY_TIMEOUT must be in 1..65535");
  end

  localparam bit          Narrow   = (BUS_WIDTH == 4);
  localparam logic [7:0]  HoldLast = 8'(HOLD - 1);
  localparam logic [15:0] PollMax  = 16'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StPoll, StXfer, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] poll_q, poll_d;
  logic        e_q, e_d, rs_q, rs_d, rw_q, rw_d;
  logic        nib_q, nib_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  wr_q, wr_d, rd_q, rd_d;
  logic        to_q, to_d;

  logic        half_end, byte_end;
  logic [15:0] poll_inc;
  logic [7:0]  din, dout;
  logic        drive;

  assign din = 8'(data_pins);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and pin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      poll_q <= '0;
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      rw_q   <= 1'b0;
      nib_q  <= 1'b0;
      op_q   <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      to_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      poll_q <= poll_d;
      e_q    <= e_d;
      rs_q   <= rs_d;
      rw_q   <= rw_d;
      nib_q  <= nib_d;
      op_q   <= op_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      to_q   <= to_d;
    end
  end

  // Next state: sequence E half-phases, nibbles, busy polls and transfer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    poll_d   = poll_q;
    e_d      = e_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    nib_d    = nib_q;
    op_d     = op_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    to_d     = to_q;
    half_end = (cnt_q >= HoldLast);
    byte_end = !Narrow || nib_q;
    poll_inc = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StPoll;
          op_d    = op;
          wr_d    = wr_data;
          to_d    = 1'b0;
          poll_d  = '0;
          cnt_d   = '0;
          nib_d   = 1'b0;
          e_d     = 1'b1;
          rs_d    = 1'b0;
          rw_d    = 1'b1;
        end
      end
      StPoll, StXfer: begin
        if (!half_end) begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else if (e_q) begin
          // Last clock of E high: capture the bus on reads.
          cnt_d = '0;
          e_d   = 1'b0;
          if (rw_q) begin
            if (!Narrow)    rd_d = din;
            else if (nib_q) rd_d = {rd_q[7:4], din[3:0]};
            else            rd_d = {din[3:0], rd_q[3:0]};
          end
        end else begin
          cnt_d = '0;
          if (!byte_end) begin
            nib_d = 1'b1;
            e_d   = 1'b1;
          end else begin
            nib_d = 1'b0;
            if (state_q == StXfer) begin
              state_d = StDone;
              rs_d    = 1'b0;
              rw_d    = 1'b0;
            end else if (!rd_q[7]) begin
              // Not busy: status reads finish here, others transfer.
              if (op_q == 2'b11) begin
                state_d = StDone;
                rs_d    = 1'b0;
                rw_d    = 1'b0;
              end else begin
                state_d = StXfer;
                e_d     = 1'b1;
                rs_d    = (op_q == 2'b01) || (op_q == 2'b10);
                rw_d    = op_q[1];
              end
            end else begin
              poll_d = poll_inc;
              if (poll_inc >= PollMax) begin
                state_d = StDone;
                to_d    = 1'b1;
                rs_d    = 1'b0;
                rw_d    = 1'b0;
              end else begin
                e_d = 1'b1;
              end
            end
          end
        end
      end
      StDone: begin
        if (!req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state: handshake and data bus drive.
  always_comb begin
    ack   = (state_q == StDone);
    drive = (state_q == StXfer) && !rw_q;
    if (!Narrow)    dout = wr_q;
    else if (nib_q) dout = {4'h0, wr_q[3:0]};
    else            dout = {4'h0, wr_q[7:4]};
  end

  assign data_pins = drive ? dout[BUS_WIDTH-1:0] : {BUS_WIDTH{1'bz}};
  assign e_pin     = e_q;
  assign rs_pin    = rs_q;
  assign rw_pin    = rw_q;
  assign rd_data   = rd_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_lcd_bus_controller.sv
// Bench for lcd_bus_controller: an 8-bit and a 4-bit instance, each attached
// to a behavioural LCD model. Results and every observed bus cycle are
// compared with expectations derived from the request and the model setup.
module tb_lcd_bus_controller;

  localparam int Hold     = 4;
  localparam int Timeout  = 3;
  localparam int LatBound = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_s = '0, e_s, rs_s, rw_s, ack_s, to_s;
  logic [3:0]  op_s = '0;
  logic [15:0] wr_s = '0;
  logic [15:0] rd_s;
  wire  [7:0]  data8;
  wire  [3:0]  data4;

  int checks = 0;
  int errors = 0;

  // LCD model state per instance (0 = 8-bit, 1 = 4-bit).
  int         mdl_busy [2];
  logic [7:0] mdl_stat [2];
  logic [7:0] mdl_dat  [2];
  bit         mdl_nib  [2];
  logic [7:0] mb0, mb1;

  typedef struct {
    int         d;
    logic       rs;
    logic       rw;
    logic [7:0] data;
    int         hlen;
    logic       stab;
  } cyc_t;
  cyc_t mon_q[$];

  typedef struct {
    int         d;
    logic [1:0] op;
    logic [7:0] w;
    int         bn;
    logic [7:0] st;
    logic [7:0] dt;
    int         lat;
    logic       to;
    logic       rd_chk;
    logic [7:0] rd;
  } vec_t;

  lcd_bus_controller #(.BUS_WIDTH(8), .HOLD(Hold), .BUSY_TIMEOUT(Timeout)) u_dut8 (
    .clk(clk), .rst(rst), .rs_pin(rs_s[0]), .rw_pin(rw_s[0]), .e_pin(e_s[0]),
    .data_pins(data8), .req(req_s[0]), .op(op_s[1:0]), .wr_data(wr_s[7:0]),
    .rd_data(rd_s[7:0]), .ack(ack_s[0]), .timeout(to_s[0])
  );

  lcd_bus_controller #(.BUS_WIDTH(4), .HOLD(Hold), .BUSY_TIMEOUT(Timeout)) u_dut4 (
    .clk(clk), .rst(rst), .rs_pin(rs_s[1]), .rw_pin(rw_s[1]), .e_pin(e_s[1]),
    .data_pins(data4), .req(req_s[1]), .op(op_s[3:2]), .wr_data(wr_s[15:8]),
    .rd_data(rd_s[15:8]), .ack(ack_s[1]), .timeout(to_s[1])
  );

  always #5 clk = ~clk;

  // LCD drives the bus whenever the controller reads (rw=1).
  assign mb0   = rs_s[0] ? mdl_dat[0] : {mdl_busy[0] != 0, mdl_stat[0][6:0]};
  assign mb1   = rs_s[1] ? mdl_dat[1] : {mdl_busy[1] != 0, mdl_stat[1][6:0]};
  assign data8 = rw_s[0] ? mb0 : 8'bz;
  assign data4 = rw_s[1] ? (mdl_nib[1] ? mb1[3:0] : mb1[7:4]) : 4'bz;

  // Bus monitor, sampled on the falling clock edge.
  logic       e_prev [2];
  logic       c_rs [2], c_rw [2], c_stab [2];
  int         c_len [2];
  logic [7:0] c_bus [2];
  logic [7:0] bus_v;
  cyc_t       rec;
  initial begin
    for (int d = 0; d < 2; d++) begin
      e_prev[d] = 1'b0; mdl_nib[d] = 1'b0; mdl_busy[d] = 0;
      mdl_stat[d] = '0; mdl_dat[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bus_v = (d == 0) ? data8 : {4'h0, data4};
        if (rst) begin
          e_prev[d]  = 1'b0;
          mdl_nib[d] = 1'b0;
        end else begin
          if (e_s[d] && !e_prev[d]) begin
            c_rs[d] = rs_s[d]; c_rw[d] = rw_s[d]; c_len[d] = 0; c_stab[d] = 1'b1;
          end
          if (e_s[d]) begin
            c_len[d]++;
            c_bus[d] = bus_v;
            if (rs_s[d] != c_rs[d] || rw_s[d] != c_rw[d]) c_stab[d] = 1'b0;
          end
          if (!e_s[d] && e_prev[d]) begin
            if (rs_s[d] != c_rs[d] || rw_s[d] != c_rw[d]) c_stab[d] = 1'b0;
            rec = '{d, c_rs[d], c_rw[d], c_bus[d], c_len[d], c_stab[d]};
            mon_q.push_back(rec);
            if (c_rw[d]) begin
              if (d == 0 || mdl_nib[d]) begin
                if (!c_rs[d] && mdl_busy[d] > 0) mdl_busy[d]--;
                mdl_nib[d] = 1'b0;
              end else begin
                mdl_nib[d] = 1'b1;
              end
            end
          end
          e_prev[d] = e_s[d];
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full handshake; optionally scrambles inputs after latch and holds req in DONE.
  task automatic run_op(input int d, input logic [1:0] o, input logic [7:0] w, input int bn,
                        input logic [7:0] st, input logic [7:0] dt, input bit scramble,
                        input int hold, output int lat, output logic to_v,
                        output logic [7:0] rd_v);
    mdl_busy[d] = bn; mdl_stat[d] = st; mdl_dat[d] = dt;
    @(negedge clk);
    mon_q.delete();
    req_s[d] = 1'b1; op_s[2*d +: 2] = o; wr_s[8*d +: 8] = w;
    lat = 0;
    while (ack_s[d] !== 1'b1 && lat < LatBound) begin
      @(posedge clk); #1; lat++;
      if (scramble && lat == 1) begin
        op_s[2*d +: 2] = 2'($urandom); wr_s[8*d +: 8] = 8'($urandom);
      end
    end
    to_v = to_s[d];
    rd_v = rd_s[8*d +: 8];
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk("hold_ack", ack_s[d], 1);
      chk("hold_rd", rd_s[8*d +: 8], rd_v);
      chk("hold_timeout", to_s[d], to_v);
    end
    @(negedge clk); req_s[d] = 1'b0;
    @(posedge clk); #1;
    chk("ack_release", ack_s[d], 0);
    repeat (2) @(negedge clk);
  endtask

  // Expected outcome from the protocol rules: polls until not busy or timeout,
  // then one byte transfer unless it was a status read.
  task automatic check_op(input int d, input logic [1:0] o, input logic [7:0] w, input int bn,
                          input logic [7:0] st, input logic [7:0] dt, input int lat,
                          input logic to_v, input logic [7:0] rd_v);
    int k, polls, nx, np;
    logic eto, ers, erw;
    logic [7:0] ed;
    cyc_t c;
    k     = (d == 0) ? 1 : 2;
    eto   = (bn >= Timeout);
    polls = eto ? Timeout : bn + 1;
    np    = polls * k;
    nx    = (!eto && o != 2'b11) ? k : 0;
    chk($sformatf("latency d%0d op%0d", d, o), lat, (np + nx) * 2 * Hold + 1);
    chk($sformatf("timeout d%0d op%0d", d, o), to_v, eto);
    if (!eto && o == 2'b11) chk("rd_status", rd_v, {1'b0, st[6:0]});
    if (!eto && o == 2'b10) chk("rd_data", rd_v, dt);
    chk("bus_cycles", mon_q.size(), np + nx);
    foreach (mon_q[i]) begin
      if (i < np + nx) begin
        c = mon_q[i];
        ers = (i < np) ? 1'b0 : (o == 2'b01 || o == 2'b10);
        erw = (i < np) ? 1'b1 : o[1];
        chk($sformatf("cyc%0d_ctl {rs,rw,stable,hlen}", i), {c.rs, c.rw, c.stab, 8'(c.hlen)},
            {ers, erw, 1'b1, 8'(Hold)});
        if (!erw) begin
          if (k == 1)         ed = w;
          else if (i == np)   ed = {4'h0, w[7:4]};
          else                ed = {4'h0, w[3:0]};
          chk($sformatf("cyc%0d_wdata", i), c.data, ed);
        end
      end
    end
  endtask

  vec_t       tbl [12];
  int         lat, n;
  logic       to_v;
  logic [7:0] rd_v;
  int         rd_, ro, rw_, rb;
  logic [7:0] rst_, rdt;

  initial begin
    tbl[0]  = '{0, 2'b00, 8'h38, 0, 8'h00, 8'h00, 17, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1, 2'b01, 8'hA5, 0, 8'h00, 8'h00, 33, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{0, 2'b00, 8'h55, 9, 8'h00, 8'h00, 25, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1, 2'b00, 8'h55, 9, 8'h00, 8'h00, 49, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{0, 2'b10, 8'h00, 0, 8'h00, 8'h41, 17, 1'b0, 1'b1, 8'h41};
    tbl[5]  = '{1, 2'b10, 8'h00, 0, 8'h00, 8'h41, 33, 1'b0, 1'b1, 8'h41};
    tbl[6]  = '{0, 2'b11, 8'h00, 0, 8'h2C, 8'h00,  9, 1'b0, 1'b1, 8'h2C};
    tbl[7]  = '{1, 2'b11, 8'h00, 0, 8'h2C, 8'h00, 17, 1'b0, 1'b1, 8'h2C};
    tbl[8]  = '{0, 2'b01, 8'hC3, 2, 8'h00, 8'h00, 33, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1, 2'b00, 8'h28, 1, 8'h00, 8'h00, 49, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{0, 2'b11, 8'h00, 1, 8'hFF, 8'h00, 17, 1'b0, 1'b1, 8'h7F};
    tbl[11] = '{1, 2'b10, 8'h00, 2, 8'h00, 8'hE7, 65, 1'b0, 1'b1, 8'hE7};

    // Reset values.
    #1 rst = 1'b1;
    #2;
    chk("rst_e", e_s, 0);
    chk("rst_rs", rs_s, 0);
    chk("rst_rw", rw_s, 0);
    chk("rst_ack", ack_s, 0);
    chk("rst_timeout", to_s, 0);
    chk("rst_rd", rd_s, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].d, tbl[i].op, tbl[i].w, tbl[i].bn, tbl[i].st, tbl[i].dt, 1'b0, 0,
             lat, to_v, rd_v);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_timeout", i), to_v, tbl[i].to);
      if (tbl[i].rd_chk) chk($sformatf("vec%0d_rd", i), rd_v, tbl[i].rd);
      check_op(tbl[i].d, tbl[i].op, tbl[i].w, tbl[i].bn, tbl[i].st, tbl[i].dt, lat, to_v, rd_v);
    end

    // Randomized requests with input scrambling and req held through DONE.
    for (int i = 0; i < 40; i++) begin
      rd_  = int'($urandom_range(0, 1));
      ro   = int'($urandom_range(0, 3));
      rw_  = int'($urandom_range(0, 255));
      rb   = int'($urandom_range(0, 4));
      rst_ = 8'($urandom);
      rdt  = 8'($urandom);
      run_op(rd_, 2'(ro), 8'(rw_), rb, rst_, rdt, 1'b1, int'($urandom_range(0, 3)),
             lat, to_v, rd_v);
      check_op(rd_, 2'(ro), 8'(rw_), rb, rst_, rdt, lat, to_v, rd_v);
    end

    // req dropped early: the write still completes and ack pulses once.
    mdl_busy[0] = 0;
    @(negedge clk);
    mon_q.delete();
    req_s[0] = 1'b1; op_s[1:0] = 2'b01; wr_s[7:0] = 8'h5A;
    lat = 0;
    while (ack_s[0] !== 1'b1 && lat < LatBound) begin
      @(posedge clk); #1; lat++;
      if (lat == 2) req_s[0] = 1'b0;
    end
    to_v = to_s[0];
    @(posedge clk); #1;
    chk("early_drop_ack_clear", ack_s[0], 0);
    check_op(0, 2'b01, 8'h5A, 0, 8'h00, 8'h00, lat, to_v, 8'h00);
    repeat (2) @(negedge clk);

    // Reset during E-high of the write cycle.
    mdl_busy[0] = 0;
    @(negedge clk);
    mon_q.delete();
    req_s[0] = 1'b1; op_s[1:0] = 2'b00; wr_s[7:0] = 8'h38;
    n = 0;
    while (!(mon_q.size() == 1 && e_s[0]) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("rst_mid_reached_write", n < 100, 1);
    chk("rst_mid_bus_before", data8, 8'h38);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_e", e_s[0], 0);
    chk("rst_mid_ack", ack_s[0], 0);
    chk("rst_mid_rs_rw", {rs_s[0], rw_s[0]}, 0);
    chk("rst_mid_rd_to", {rd_s[7:0], to_s[0]}, 0);
    req_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_q.delete();
    repeat (10) @(negedge clk);
    chk("rst_mid_no_e_pulse", mon_q.size(), 0);
    run_op(0, 2'b00, 8'h38, 0, 8'h00, 8'h00, 1'b0, 0, lat, to_v, rd_v);
    check_op(0, 2'b00, 8'h38, 0, 8'h00, 8'h00, lat, to_v, rd_v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_controller.md
LCD_BUS_CONTROLLER -- requirements
Module: lcd_bus_controller

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8: HD44780 data bus width; legal values 8 or 4.
REQ-002 SHALL have parameter HOLD, default 150: clock cycles per E half-phase (E high, then E low); legal range 2..255.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 1000: maximum busy polls per request; legal range 1..65535.
REQ-004 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have ports rs_pin, rw_pin, e_pin, each output, 1: LCD control pins, registered.
REQ-007 SHALL have port data_pins, inout, BUS_WIDTH: LCD data bus; in 4-bit mode it maps to DB7..DB4.
REQ-008 SHALL have port req, input, 1: request; 4-phase handshake with ack.
REQ-009 SHALL have port op, input, 2: 00 write command, 01 write data, 10 read data, 11 read status.
REQ-010 SHALL have port wr_data, input, 8: byte to write.
REQ-011 SHALL have port rd_data, output, 8: byte read, valid while ack=1.
REQ-012 SHALL have port ack, output, 1: request complete.
REQ-013 SHALL have port timeout, output, 1: last request was aborted because the LCD stayed busy; valid while ack=1.

Function
REQ-014 SHALL implement states IDLE, POLL, XFER and DONE.
REQ-015 Bus cycle definition, SHALL hold:
- E=1 for HOLD clk, then E=0 for HOLD clk.
- rs/rw stable for the whole bus cycle.
- Read data sampled on the last clk of the E-high half.
REQ-016 Nibble rule: in 4-bit mode every byte access SHALL be two bus cycles, high nibble first; in 8-bit mode it SHALL be one bus cycle.
REQ-017 IDLE: on req=1, SHALL latch op and wr_data, clear timeout and the poll count, and go to POLL.
REQ-018 POLL: SHALL perform byte reads with rs=0, rw=1.
- Busy = DB7 of the first (or only) bus cycle.
- Busy=0: SHALL go to XFER.
- Busy=1: SHALL increment the poll count.
- Poll count reaching BUSY_TIMEOUT: SHALL set timeout=1 and go to DONE.
REQ-019 op=11 SHALL complete within POLL: the sampled status byte goes to rd_data, then go to DONE without an XFER.
REQ-020 XFER: SHALL set rs=(op!=00 and op!=11) and rw=op[1], perform one byte access, then go to DONE.
REQ-021 data_pins SHALL be driven only in XFER with rw=0, carrying the current wr_data byte or nibble; otherwise high-Z.
REQ-022 Reads SHALL assemble rd_data from sampled bits; in 4-bit mode {first nibble, second nibble}.
REQ-023 DONE: SHALL hold ack=1 combinationally from state; rd_data and timeout SHALL stay stable.
REQ-024 DONE: on req=0, SHALL return to IDLE the next clk.
REQ-025 req falling before DONE SHALL be ignored; the operation completes.
REQ-026 req held high through DONE->IDLE SHALL be seen as a new request only after req has been 0 in DONE.
REQ-027 Minimum latency, req to ack, 8-bit write:
- 4*HOLD+1 clk.
- 4-bit write: 8*HOLD+1 clk.
REQ-028 Counters SHALL saturate and never wrap:
- Half-phase counter: 8 bit.
- Poll counter: 16 bit.
REQ-029 Parameter values out of range SHALL be rejected at elaboration.

Reset
REQ-030 On rst=1, SHALL immediately apply:
- State IDLE.
- e_pin=0, rs_pin=0, rw_pin=0.
- data_pins high-Z.
- ack=0, timeout=0, rd_data=0x00.
- All counters 0.
REQ-031 Reset mid-operation SHALL abort with no further E pulse; the first request after reset restarts from POLL.

Verification
REQ-032 BUS_WIDTH=8, HOLD=4: op=00, wr_data=0x38, LCD model not busy -> one poll cycle (rs0 rw1, E 4 high/4 low), then write cycle with data_pins=0x38, rs0; ack at clk 17.
REQ-033 BUS_WIDTH=4, HOLD=4: op=01, wr_data=0xA5 -> two poll nibbles, then data_pins=0xA then 0x5 with rs1 rw0; ack after 33 clk.
REQ-034 BUSY_TIMEOUT=3: model DB7 stuck 1 -> exactly 3 polls, no write cycle, ack=1 with timeout=1; data_pins never driven.
REQ-035 op=10, model returns 0x41 (4-bit: 0x4 then 0x1) -> rd_data=0x41 at ack, rs1 rw1 in XFER, timeout=0.
REQ-036 op=11, model status 0x2C -> no XFER, rd_data=0x2C, ack after one poll.
REQ-037 rst pulsed during the E-high half of the write -> same cycle e_pin=0, bus high-Z, ack=0; next request completes normally.
